frac_window_avg: RTL and testbench
==================================

Name: frac_window_avg

Overview:
- Downstream consumer of the fractional-counter stage.
- Takes each 16-bit fractional phase result together with its write strobe.
- Averages consecutive results over a fixed power-of-two window and presents the rounded mean on a valid/ready output register.
- Accumulation of the next window continues while a result waits; the readout logic (host interface / FIFO) pulls results at its own pace.

Parameters:
- FRAC_W, 16, width of incoming fractional result and of the mean.
- AVG_LOG2, 4, log2 of window length N; legal range 0..8.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous window restart; same effect as rst.
- frac_in  in  FRAC_W  fractional result from upstream.
- frac_wr  in  1  one-cycle strobe; frac_in is valid this cycle.
- avg_out  out  FRAC_W  rounded window mean.
- avg_valid  out  1  avg_out holds an unconsumed result.
- avg_ready  in  1  consumer accepts avg_out when avg_valid & avg_ready.
- overrun  out  1  sticky: a completed window was dropped.
- win_cnt  out  AVG_LOG2+1  samples accumulated in the current window.

Behaviour:
- Reset (rst or clear): acc=0, win_cnt=0, avg_out=0, avg_valid=0, overrun=0.
- rst/clear has priority over a same-cycle frac_wr; that sample is discarded.
- Accumulator acc is FRAC_W+AVG_LOG2 bits; no overflow is possible.
- Each frac_wr cycle: acc += frac_in and win_cnt += 1.
- Window complete: frac_wr arrives while win_cnt == N-1.
  - On the next edge, mean = (acc + frac_in + 2^(AVG_LOG2-1)) >> AVG_LOG2, i.e. round half up; plain pass-through when AVG_LOG2=0.
  - Sum plus the rounding half always fits in the accumulator width, so the mean never exceeds 2^FRAC_W-1.
  - On that same edge, acc and win_cnt restart at 0; the next frac_wr begins the next window with no gap.
- Latency: avg_out/avg_valid update on the clock edge that samples the final frac_wr (visible the following cycle).
- Output register FSM, two states:
  - EMPTY: avg_valid=0. Window complete -> load avg_out, go to FULL.
  - FULL: avg_valid=1.
    - Accept (avg_ready) with no completion -> EMPTY.
    - Accept and completion in the same cycle -> load the new mean, stay FULL, no overrun.
    - Completion without accept -> new mean dropped, avg_out keeps the old value, overrun set.
- overrun clears only on rst/clear.
- avg_out is stable while avg_valid=1 and no accept has occurred.
- win_cnt counts 0..N-1 and never shows N.
- frac_wr is a strobe only; frac_in is ignored when frac_wr=0. frac_wr asserted on consecutive cycles is legal, one sample per cycle.

Optional Feature:
- Macro FRAC_WINDOW_MINMAX_EN.
- Defined:
  - Adds outputs min_out[FRAC_W-1:0] and max_out[FRAC_W-1:0].
  - These give the extremes of the window that produced avg_out, loaded together with avg_out under the same drop/accept rules.
  - Tracking restarts at every window start: first sample sets both min and max.
  - Reset value of min_out and max_out is 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package frac_pkg:
  - FRAC_W default constant.
  - AVG_LOG2_MAX=8.
  - Typedef for the output FSM state enum {EMPTY, FULL}.
  - Typedef frac_t (FRAC_W-bit logic).
- One sub-module is natural: frac_minmax_track, instantiated only under FRAC_WINDOW_MINMAX_EN. It takes sample, strobe, window start and restart, and outputs running min/max.

Test Plan (AVG_LOG2=2 unless noted):
- Samples 10,11,12,13 with avg_ready=1 -> avg_out=12, avg_valid high one cycle, overrun=0, win_cnt back to 0.
- Samples 1,2,2,2 -> sum 7+2=9>>2 -> avg_out=2; samples 1,1,1,2 -> avg_out=1 (rounding check).
- Four samples of 65535 on back-to-back cycles -> avg_out=65535, no wrap; with MINMAX_EN, min_out=max_out=65535.
- avg_ready=0, then two full windows (means 5 then 9) -> avg_out stays 5, overrun=1. Then avg_ready=1 -> valid drops, overrun stays 1 until clear.
- FULL with window completion and accept in the same cycle -> avg_out switches to new mean, avg_valid stays 1, overrun=0.
- Two samples, then clear pulsed together with a third frac_wr -> win_cnt=0, all outputs 0. Next four samples 4,4,4,4 -> avg_out=4. Check AVG_LOG2=0 build: every sample is passed through.

Source files
------------

// File: rtl/frac_window_avg_pkg.sv
// Shared types and limits for the fractional window averager.
package frac_pkg;

  localparam int unsigned FRAC_W_DEFAULT = 16;
  localparam int unsigned AVG_LOG2_MAX   = 8;

  typedef enum logic {EMPTY, FULL} out_state_e;

  typedef logic [FRAC_W_DEFAULT-1:0] frac_t;

endpackage

// File: rtl/frac_window_avg_if.sv
// Sample input and valid/ready mean output of frac_window_avg.
// FRAC_WINDOW_MINMAX_EN adds the window extremes min_out/max_out.
interface frac_window_avg_if #(
  parameter int unsigned FRAC_W   = 16,
  parameter int unsigned AVG_LOG2 = 4
);
  logic [FRAC_W-1:0] frac_in;
  logic              frac_wr;
  logic [FRAC_W-1:0] avg_out;
  logic              avg_valid;
  logic              avg_ready;
  logic              overrun;
  logic [AVG_LOG2:0] win_cnt;
`ifdef FRAC_WINDOW_MINMAX_EN
  logic [FRAC_W-1:0] min_out;
  logic [FRAC_W-1:0] max_out;
`endif

  modport master (
    output frac_in, frac_wr, avg_ready,
    input  avg_out, avg_valid, overrun, win_cnt
`ifdef FRAC_WINDOW_MINMAX_EN
    , input min_out, max_out
`endif
  );

  modport slave (
    input  frac_in, frac_wr, avg_ready,
    output avg_out, avg_valid, overrun, win_cnt
`ifdef FRAC_WINDOW_MINMAX_EN
    , output min_out, max_out
`endif
  );
endinterface

// File: rtl/frac_window_avg_minmax_track.sv
// Running min/max of the current window; min_o/max_o already include a
// sample strobed this cycle so the window extremes are ready on completion.
module frac_minmax_track #(
  parameter int unsigned FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FRAC_W-1:0] sample_i,
  input  logic              strobe_i,
  input  logic              start_i,
  output logic [FRAC_W-1:0] min_o,
  output logic [FRAC_W-1:0] max_o
);
  logic [FRAC_W-1:0] run_min_q;
  logic [FRAC_W-1:0] run_max_q;

  always_comb begin
    min_o = sample_i;
    max_o = sample_i;
    if (!start_i) begin
      if (run_min_q < sample_i) min_o = run_min_q;
      if (run_max_q > sample_i) max_o = run_max_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min_q <= '0;
      run_max_q <= '0;
    end else if (strobe_i) begin
      run_min_q <= min_o;
      run_max_q <= max_o;
    end
  end
endmodule

// File: rtl/frac_window_avg.sv
// Averages 2**AVG_LOG2 fractional results into a rounded mean on a valid/ready
// register. Optional FRAC_WINDOW_MINMAX_EN also reports the window min/max.
module frac_window_avg
  import frac_pkg::*;
#(
  parameter int unsigned FRAC_W   = FRAC_W_DEFAULT,
  parameter int unsigned AVG_LOG2 = 4
) (
  input logic         clk,
  input logic         rst,
  input logic         clear,
  frac_window_avg_if.slave bus
);
  localparam int unsigned ACC_W = FRAC_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((2 ** AVG_LOG2) - 1);
  localparam logic [ACC_W-1:0] HALF = ACC_W'((2 ** AVG_LOG2) >> 1);

  if (AVG_LOG2 > AVG_LOG2_MAX) begin : g_bad_log2
    $error("frac_window_avg: AVG_LOG2 out of range");
  end

  logic [ACC_W-1:0]  acc_q, acc_d, sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] avg_q, mean;
  logic              ovr_q;
  out_state_e        state_q;
  logic              restart, complete, load;

  assign restart  = rst | clear;
  assign complete = bus.frac_wr && (cnt_q == LAST);
  // Sum plus half never exceeds ACC_W bits, so no carry-out is needed.
  assign sum      = acc_q + ACC_W'(bus.frac_in) + HALF;
  assign mean     = FRAC_W'(sum >> AVG_LOG2);
  assign load     = complete && ((state_q == EMPTY) || bus.avg_ready);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (complete) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (bus.frac_wr) begin
      acc_d = acc_q + ACC_W'(bus.frac_in);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
      ovr_q   <= 1'b0;
      state_q <= EMPTY;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (load) avg_q <= mean;
      if (complete && (state_q == FULL) && !bus.avg_ready) ovr_q <= 1'b1;
      case (state_q)
        EMPTY:   if (complete) state_q <= FULL;
        FULL:    if (bus.avg_ready && !complete) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign bus.avg_out   = avg_q;
  assign bus.avg_valid = (state_q == FULL);
  assign bus.overrun   = ovr_q;
  assign bus.win_cnt   = cnt_q;

`ifdef FRAC_WINDOW_MINMAX_EN
  logic [FRAC_W-1:0] win_min, win_max, min_q, max_q;

  frac_minmax_track #(.FRAC_W(FRAC_W)) u_minmax (
    .clk      (clk),
    .rst      (restart),
    .sample_i (bus.frac_in),
    .strobe_i (bus.frac_wr),
    .start_i  (cnt_q == '0),
    .min_o    (win_min),
    .max_o    (win_max)
  );

  always_ff @(posedge clk) begin
    if (restart) begin
      min_q <= '0;
      max_q <= '0;
    end else if (load) begin
      min_q <= win_min;
      max_q <= win_max;
    end
  end

  assign bus.min_out = min_q;
  assign bus.max_out = max_q;
`endif
endmodule

// File: tb/tb_frac_window_avg.sv
// Bench for frac_window_avg: AVG_LOG2=2 and AVG_LOG2=0 instances against a
// sum/count reference model, plus table vectors and directed corner cases.
module tb_frac_window_avg;
  import frac_pkg::*;

  localparam int unsigned L2 = 2;
  localparam int unsigned N  = 4;

  logic clk = 1'b0;
  logic rst, clear;
  always #5 clk = ~clk;

  frac_window_avg_if #(.FRAC_W(16), .AVG_LOG2(L2)) bus ();
  frac_window_avg_if #(.FRAC_W(16), .AVG_LOG2(0))  bus0 ();

  assign bus0.frac_in   = bus.frac_in;
  assign bus0.frac_wr   = bus.frac_wr;
  assign bus0.avg_ready = bus.avg_ready;

  frac_window_avg #(.FRAC_W(16), .AVG_LOG2(L2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus));
  frac_window_avg #(.FRAC_W(16), .AVG_LOG2(0)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus0));

  typedef struct {
    int unsigned sum, cnt, mn, mx, val, vmin, vmax;
    bit          valid, ovr;
  } model_t;

  typedef struct {
    frac_t s[4];
    frac_t mean, mn, mx;
  } vec_t;

  model_t m4, m1;
  int unsigned checks = 0;
  int unsigned passes = 0;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: running sum/count per window, mean by integer division.
  task automatic model_step(input model_t mi, input int unsigned n, input bit clr,
                            input bit wr, input bit rdy, input int unsigned x,
                            output model_t mo);
    bit complete;
    mo = mi;
    if (clr) begin
      mo = '{default: 0};
      return;
    end
    complete = wr && (mi.cnt + 1 == n);
    if (wr) begin
      if (mi.cnt == 0) begin mo.mn = x; mo.mx = x; end
      else begin
        if (x < mi.mn) mo.mn = x;
        if (x > mi.mx) mo.mx = x;
      end
      mo.sum = mi.sum + x;
      mo.cnt = mi.cnt + 1;
    end
    if (complete) begin
      if (!mi.valid || rdy) begin
        mo.valid = 1'b1;
        mo.val   = (mo.sum + n / 2) / n;
        mo.vmin  = mo.mn;
        mo.vmax  = mo.mx;
      end else begin
        mo.ovr = 1'b1;
      end
      mo.sum = 0;
      mo.cnt = 0;
    end else if (rdy) begin
      mo.valid = 1'b0;
    end
  endtask

  task automatic compare_models();
    chk("valid",   bus.avg_valid, m4.valid);
    chk("avg_out", bus.avg_out,   m4.val);
    chk("overrun", bus.overrun,   m4.ovr);
    chk("win_cnt", bus.win_cnt,   m4.cnt);
    chk("l0_valid",   bus0.avg_valid, m1.valid);
    chk("l0_avg_out", bus0.avg_out,   m1.val);
    chk("l0_overrun", bus0.overrun,   m1.ovr);
    chk("l0_win_cnt", bus0.win_cnt,   m1.cnt);
`ifdef FRAC_WINDOW_MINMAX_EN
    chk("min_out",    bus.min_out,  m4.vmin);
    chk("max_out",    bus.max_out,  m4.vmax);
    chk("l0_min_out", bus0.min_out, m1.vmin);
    chk("l0_max_out", bus0.max_out, m1.vmax);
`endif
  endtask

  task automatic tick();
    model_step(m4, N, rst | clear, bus.frac_wr, bus.avg_ready, bus.frac_in, m4);
    model_step(m1, 1, rst | clear, bus.frac_wr, bus.avg_ready, bus.frac_in, m1);
    @(posedge clk);
    #1;
    compare_models();
  endtask

  task automatic send(input int unsigned x, input bit rdy);
    bus.frac_wr   = 1'b1;
    bus.frac_in   = 16'(x);
    bus.avg_ready = rdy;
    tick();
    bus.frac_wr   = 1'b0;
  endtask

  task automatic idle(input bit rdy);
    bus.frac_wr   = 1'b0;
    bus.avg_ready = rdy;
    tick();
  endtask

  initial begin
    tbl[0] = '{s: '{10, 11, 12, 13},          mean: 12,    mn: 10,    mx: 13};
    tbl[1] = '{s: '{1, 2, 2, 2},              mean: 2,     mn: 1,     mx: 2};
    tbl[2] = '{s: '{1, 1, 1, 2},              mean: 1,     mn: 1,     mx: 2};
    tbl[3] = '{s: '{65535, 65535, 65535, 65535}, mean: 65535, mn: 65535, mx: 65535};
    tbl[4] = '{s: '{4, 4, 4, 4},              mean: 4,     mn: 4,     mx: 4};
    tbl[5] = '{s: '{0, 0, 1, 1},              mean: 1,     mn: 0,     mx: 1};
    tbl[6] = '{s: '{0, 0, 0, 1},              mean: 0,     mn: 0,     mx: 1};
    tbl[7] = '{s: '{9, 3, 200, 7},            mean: 55,    mn: 3,     mx: 200};

    m4 = '{default: 0};
    m1 = '{default: 0};
    rst = 1'b1; clear = 1'b0;
    bus.frac_wr = 1'b0; bus.frac_in = '0; bus.avg_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_avg_out", bus.avg_out, 0);
    chk("rst_valid",   bus.avg_valid, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_win_cnt", bus.win_cnt, 0);

    // Table: one window per entry, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        send(tbl[i].s[k], 1'b1);
        chk("l0_pass", bus0.avg_out, tbl[i].s[k]);
        if (k < 3) chk("tbl_win_cnt", bus.win_cnt, k + 1);
      end
      chk("tbl_valid",   bus.avg_valid, 1);
      chk("tbl_mean",    bus.avg_out, tbl[i].mean);
      chk("tbl_overrun", bus.overrun, 0);
      chk("tbl_win_cnt0", bus.win_cnt, 0);
`ifdef FRAC_WINDOW_MINMAX_EN
      chk("tbl_min", bus.min_out, tbl[i].mn);
      chk("tbl_max", bus.max_out, tbl[i].mx);
`endif
      idle(1'b1);
      chk("tbl_drain", bus.avg_valid, 0);
    end

    // Stalled consumer: second window dropped, first mean held.
    for (int k = 0; k < 4; k++) send(5, 1'b0);
    for (int k = 0; k < 4; k++) send(9, 1'b0);
    chk("ovr_hold", bus.avg_out, 5);
    chk("ovr_flag", bus.overrun, 1);
    chk("ovr_valid", bus.avg_valid, 1);
    idle(1'b1);
    chk("ovr_drain", bus.avg_valid, 0);
    chk("ovr_sticky", bus.overrun, 1);
    clear = 1'b1;
    idle(1'b0);
    clear = 1'b0;
    chk("ovr_clear", bus.overrun, 0);

    // Accept and completion coincide: new mean replaces old, no overrun.
    for (int k = 0; k < 4; k++) send(3, 1'b0);
    chk("acc_first", bus.avg_out, 3);
    for (int k = 0; k < 3; k++) send(7, 1'b0);
    send(7, 1'b1);
    chk("acc_valid", bus.avg_valid, 1);
    chk("acc_mean",  bus.avg_out, 7);
    chk("acc_ovr",   bus.overrun, 0);
    idle(1'b1);

    // Clear beats a same-cycle strobe; next window starts clean.
    send(8, 1'b1);
    send(8, 1'b1);
    clear = 1'b1;
    send(50, 1'b1);
    clear = 1'b0;
    chk("clr_win_cnt", bus.win_cnt, 0);
    chk("clr_avg_out", bus.avg_out, 0);
    chk("clr_valid",   bus.avg_valid, 0);
    chk("clr_overrun", bus.overrun, 0);
    for (int k = 0; k < 4; k++) send(4, 1'b1);
    chk("clr_next_mean", bus.avg_out, 4);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      clear         = ($urandom_range(0, 49) == 0);
      bus.frac_wr   = ($urandom_range(0, 9) < 7);
      bus.avg_ready = 1'($urandom_range(0, 1));
      bus.frac_in   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      tick();
    end
    clear = 1'b0;
    bus.frac_wr = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
